// File: rtl/pipe_inv_pkg.sv
// Shared definitions for the operand-recovery block: default widths and FSM encoding.
package pipe_inv_pkg;

  localparam int unsigned DefWIn  = 2;
  localparam int unsigned DefWOut = 2 * DefWIn;
  localparam int unsigned DefCntW = $clog2(DefWOut);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StFix  = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_operand_recovery_if.sv
// Start/busy/done request bus carrying the operands in and the recovered operand plus flags out.
interface pipeline_operand_recovery_if #(
  parameter int unsigned WIn  = 2,
  parameter int unsigned WOut = 4
);

  logic            start;
  logic [WOut-1:0] out_val;
  logic [WIn-1:0]  b;
  logic [WIn-1:0]  c;
  logic [WIn-1:0]  d;
  logic            busy;
  logic            done;
  logic [WIn-1:0]  a_rec;
  logic            err_div0;
  logic            err_range;

  modport master (
    output start, out_val, b, c, d,
    input  busy, done, a_rec, err_div0, err_range
  );

  modport slave (
    input  start, out_val, b, c, d,
    output busy, done, a_rec, err_div0, err_range
  );

endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift in the next numerator bit, subtract the divisor if it fits.
module restoring_div_step #(
  parameter int unsigned WIn = 2
) (
  input  logic [WIn:0]   rem_i,
  input  logic           num_bit_i,
  input  logic [WIn-1:0] dvs_i,
  output logic [WIn:0]   rem_o,
  output logic           q_bit_o
);

  logic [WIn+1:0] shifted;
  logic [WIn+1:0] dvs_ext;
  logic [WIn+1:0] diff;

  always_comb begin
    shifted = {rem_i, num_bit_i};
    dvs_ext = {2'b00, dvs_i};
    diff    = shifted - dvs_ext;
    q_bit_o = (shifted >= dvs_ext);
    // With a zero divisor every step "fits"; the remainder is meaningless then and masked later.
    rem_o   = q_bit_o ? diff[WIn:0] : shifted[WIn:0];
  end

endmodule

// File: rtl/pipeline_operand_recovery.sv
// Recovers operand a from ((a+b)*d - c) by computing ((out_val + c) / d - b) with a serial divider.
module pipeline_operand_recovery
  import pipe_inv_pkg::*;
#(
  parameter int unsigned WIn  = DefWIn,
  parameter int unsigned WOut = 2 * WIn
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  pipeline_operand_recovery_if.slave bus
);

  localparam int unsigned CntW = (WOut > 1) ? $clog2(WOut) : 1;

  state_e          state_q, state_d;
  logic [WOut-1:0] num_q, num_d;
  logic [WOut-1:0] quo_q, quo_d;
  logic [WIn:0]    rem_q, rem_d;
  logic [WIn-1:0]  dvs_q, dvs_d;
  logic [WIn-1:0]  b_q, b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIn-1:0]  a_rec_q, a_rec_d;
  logic            done_q, done_d;
  logic            err_div0_q, err_div0_d;
  logic            err_range_q, err_range_d;

  logic [WIn:0]    step_rem;
  logic            step_q;
  logic            fix_div0;
  logic            fix_range;
  logic [WIn-1:0]  fix_a;

  restoring_div_step #(
    .WIn(WIn)
  ) u_div_step (
    .rem_i    (rem_q),
    .num_bit_i(num_q[cnt_q]),
    .dvs_i    (dvs_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  always_comb begin
    fix_div0  = (dvs_q == '0);
    fix_range = !fix_div0 && ((rem_q != '0) || (quo_q[WOut-1:WIn] != '0));
    fix_a     = quo_q[WIn-1:0] - b_q;
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    a_rec_d     = a_rec_q;
    err_div0_d  = err_div0_q;
    err_range_d = err_range_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          // Wraps mod 2^WOut, undoing the forward datapath's subtract wrap.
          num_d   = bus.out_val + {{(WOut - WIn){1'b0}}, bus.c};
          dvs_d   = bus.d;
          b_d     = bus.b;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CntW'(WOut - 1);
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d        = step_rem;
        quo_d[cnt_q] = step_q;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        err_div0_d  = fix_div0;
        err_range_d = fix_range;
        a_rec_d     = (fix_div0 || fix_range) ? '0 : fix_a;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      num_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      a_rec_q     <= '0;
      done_q      <= 1'b0;
      err_div0_q  <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      a_rec_q     <= a_rec_d;
      done_q      <= done_d;
      err_div0_q  <= err_div0_d;
      err_range_q <= err_range_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.a_rec     = a_rec_q;
  assign bus.err_div0  = err_div0_q;
  assign bus.err_range = err_range_q;

endmodule

// File: tb/tb_pipeline_operand_recovery.sv
// Directed bench for pipeline_operand_recovery: spec vectors, handshake, reset abort, forward sweep.
module tb_pipeline_operand_recovery;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_operand_recovery_if #(.WIn(2), .WOut(4)) bus ();

  pipeline_operand_recovery #(
    .WIn (2),
    .WOut(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {err_div0, err_range, a_rec}
  function automatic logic [31:0] res();
    return 32'({bus.err_div0, bus.err_range, bus.a_rec});
  endfunction

  task automatic do_op(input logic [3:0] ov, input logic [1:0] bb, input logic [1:0] cc,
                       input logic [1:0] dd, input bit poke, output int lat);
    @(negedge clk);
    bus.out_val = ov;
    bus.b       = bb;
    bus.c       = cc;
    bus.d       = dd;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.out_val = ~ov;
    bus.b       = ~bb;
    bus.c       = ~cc;
    bus.d       = ~dd;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke && lat == 3) bus.start = 1'b1;
      if (poke && lat == 4) bus.start = 1'b0;
    end
  endtask

  task automatic run_check(input string tag, input logic [3:0] ov, input logic [1:0] bb,
                           input logic [1:0] cc, input logic [1:0] dd, input bit poke,
                           input logic [31:0] exp);
    int lat;
    do_op(ov, bb, cc, dd, poke, lat);
    check_eq({tag, ":lat"}, 32'(lat), 32'd6);
    check_eq({tag, ":res"}, res(), exp);
    @(posedge clk);
    #1;
    check_eq({tag, ":idle"}, 32'({bus.done, bus.busy}), 32'd0);
  endtask

  initial begin
    logic [31:0] mask;
    logic        seen;
    logic [3:0]  ov;

    bus.start   = 1'b0;
    bus.out_val = '0;
    bus.b       = '0;
    bus.c       = '0;
    bus.d       = '0;
    #12;
    check_eq("reset_out", 32'({bus.busy, bus.done, bus.err_div0, bus.err_range, bus.a_rec}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("basic",   4'd8,  2'd1, 2'd1, 2'd3, 1'b0, 32'h2);
    run_check("wrap",    4'd2,  2'd3, 2'd2, 2'd2, 1'b0, 32'h3);
    run_check("sumwrap", 4'd13, 2'd0, 2'd3, 2'd1, 1'b0, 32'h0);
    run_check("div0",    4'd5,  2'd2, 2'd1, 2'd0, 1'b0, 32'h8);
    run_check("rem",     4'd4,  2'd0, 2'd0, 2'd3, 1'b0, 32'h4);
    run_check("qbig",    4'd8,  2'd0, 2'd0, 2'd2, 1'b0, 32'h4);
    run_check("poke",    4'd2,  2'd3, 2'd2, 2'd2, 1'b1, 32'h3);

    // start held high: accepts at edges 0, 6, 12; done after edges 5, 11, 17
    @(negedge clk);
    bus.out_val = 4'd8;
    bus.b       = 2'd1;
    bus.c       = 2'd1;
    bus.d       = 2'd3;
    bus.start   = 1'b1;
    @(posedge clk);
    mask = '0;
    for (int t = 1; t <= 17; t++) begin
      @(posedge clk);
      #1;
      mask[t] = bus.done;
      if (t == 17) bus.start = 1'b0;
    end
    check_eq("b2b_mask", mask, (32'd1 << 5) | (32'd1 << 11) | (32'd1 << 17));
    check_eq("b2b_res", res(), 32'h2);
    @(posedge clk);
    #1;
    check_eq("b2b_idle", 32'({bus.done, bus.busy}), 32'd0);

    // reset during the second divide cycle
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_abort", 32'({bus.busy, bus.done, bus.err_div0, bus.err_range, bus.a_rec}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | bus.done | bus.busy;
    end
    check_eq("rst_no_done", 32'(seen), 32'd0);
    run_check("post_rst", 4'd8, 2'd1, 2'd1, 2'd3, 1'b0, 32'h2);

    // forward model: out_val = ((a+b) mod 4)*d - c mod 16 must invert back to a
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 4; c++) begin
          for (int d = 1; d < 4; d++) begin
            ov = 4'((((a + b) % 4) * d - c) & 15);
            run_check($sformatf("fwd a%0d b%0d c%0d d%0d", a, b, c, d), ov, 2'(b), 2'(c),
                      2'(d), 1'b0, 32'(a));
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
